sync_fifo_flagged: RTL and testbench
====================================

Name: sync_fifo_flagged

Overview:
- Single-clock, parametrised FIFO that generalises the team's asynchronous FIFO for blocks that need no clock crossing.
- Adds an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a selectable first-word-fall-through (FWFT) read mode.
- Used as the elastic buffer between same-clock producer and consumer stages.

Parameters:
- DATA_WIDTH, 8, data bus width in bits.
- ADDR_WIDTH, 3, address width; depth DEPTH = 2^ADDR_WIDTH.
- ALMOST_FULL_LEVEL, 6, fill level at or above which almost_full asserts; legal range ALMOST_EMPTY_LEVEL < ALMOST_FULL_LEVEL <= DEPTH.
- ALMOST_EMPTY_LEVEL, 2, fill level at or below which almost_empty asserts; legal range 0 <= ALMOST_EMPTY_LEVEL.
- FWFT, 0, read mode: 0 = standard (registered read, 1-cycle latency); 1 = first-word-fall-through.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- write_enable  in  1  write request.
- write_data  in  DATA_WIDTH  write word.
- read_enable  in  1  read request (FWFT=1: pop of the displayed head word).
- read_data  out  DATA_WIDTH  read word.
- write_full  out  1  fill level == DEPTH.
- read_empty  out  1  fill level == 0.
- almost_full  out  1  fill level >= ALMOST_FULL_LEVEL.
- almost_empty  out  1  fill level <= ALMOST_EMPTY_LEVEL.
- fill_level  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.
- clear_errors  in  1  clears overflow and underflow.

Behaviour:
- Reset (reset_n=0 at a rising edge of clock, synchronous):
  - Pointers and fill_level go to 0; read_data goes to 0; overflow and underflow go to 0.
  - Resulting outputs: read_empty=1, write_full=0, almost_empty=1, almost_full=0.
  - Memory contents are not reset.
  - Reset overrides every other input in the same cycle. A reset in the middle of a transfer discards all stored words.
- Storage: DEPTH x DATA_WIDTH array. Read and write pointers are ADDR_WIDTH bits wide and wrap naturally from DEPTH-1 to 0.
- Write accepted iff write_enable=1 and write_full=0. On acceptance, write_data is stored at the write pointer and the pointer increments.
- Read accepted iff read_enable=1 and read_empty=0. On acceptance, the read pointer increments.
- fill_level: +1 on a write-only acceptance, -1 on a read-only acceptance, unchanged when both are accepted or neither is.
- Status flags are decoded from the registered fill_level. They change in the cycle after the accepting edge and are glitch-free.
- Simultaneous requests when empty: the write is accepted; the read is rejected and sets underflow; fill_level goes 0 -> 1.
- Simultaneous requests when full: the read is accepted; the write is rejected and sets overflow; fill_level goes DEPTH -> DEPTH-1.
- Simultaneous requests otherwise: both are accepted and fill_level is unchanged.
- FWFT=0: on an accepted read, read_data is updated at that edge with the word at the read pointer. Data is therefore visible one cycle after read_enable is sampled. read_data holds its value at all other times, including rejected reads.
- FWFT=1: whenever read_empty=0, read_data presents the head word, with no extra cycle. An accepted read advances to the next word, which is visible after the edge. The first word written into an empty FIFO appears in the cycle after the write edge, together with read_empty falling. While read_empty=1, read_data holds its last value.
- Error flags:
  - overflow sets when write_enable=1 and write_full=1.
  - underflow sets when read_enable=1 and read_empty=1.
  - Both stay set until clear_errors=1.
  - If a set condition and clear_errors occur in the same cycle, the set wins.
- No combinational path from inputs to status flags. In FWFT=1, read_data is driven from the memory array and pointer only.

Test Plan:
1. Reset, then write 0xA1, 0xB2, 0xC3 on consecutive cycles and read 3 with FWFT=0 -> read_data is 0xA1, 0xB2, 0xC3, each one cycle after its read; fill_level counts 1, 2, 3 then 2, 1, 0; read_empty=1 at the end.
2. Write 11 words (0x10..0x1A) with no reads, DEPTH=8 -> almost_full rises at level 6, write_full at level 8, overflow=1; the 3 extra words are dropped; reading back gives 0x10..0x17 only.
3. With the FIFO full, assert write_enable and read_enable for one cycle -> the read is accepted, overflow sets, fill_level=7, write_full=0.
4. With the FIFO empty, assert write_enable (0x5A) and read_enable together -> underflow=1, fill_level=1; assert clear_errors -> underflow=0 next cycle.
5. FWFT=1: write 0x77 into an empty FIFO -> next cycle read_empty=0 and read_data=0x77 without any read; pop it -> read_empty=1.
6. Wrap-around: 20 interleaved write/read pairs of an incrementing pattern -> data order is preserved across pointer wrap; assert reset_n=0 mid-stream -> fill_level=0 and read_empty=1 on the next cycle.

Source files
------------

// File: rtl/sync_fifo_flagged.sv
// sync_fifo_flagged: single-clock FIFO with occupancy count, almost-full /
// almost-empty thresholds, sticky overflow/underflow flags and an optional
// first-word-fall-through read mode. All status outputs come from flops.
module sync_fifo_flagged #(
  parameter int DATA_WIDTH         = 8,
  parameter int ADDR_WIDTH         = 3,
  parameter int ALMOST_FULL_LEVEL  = 6,
  parameter int ALMOST_EMPTY_LEVEL = 2,
  parameter int FWFT               = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_enable,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  write_full,
  output logic                  read_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clear_errors
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(ALMOST_EMPTY_LEVEL);

  // Storage array; contents deliberately survive reset.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         fill_q, fill_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  af_q, af_d;
  logic                  ae_q, ae_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] head_word;

  // Word currently at the read pointer.
  assign head_word = mem[rd_ptr_q];

  // Acceptance, pointer/occupancy update and registered flag decode.
  always_comb begin
    wr_acc    = write_enable & ~full_q;
    rd_acc    = read_enable & ~empty_q;

    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    fill_d    = fill_q;
    rd_data_d = rd_data_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_acc) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      // Standard mode: this is the registered read word.
      // FWFT mode: this remembers the last popped word so the output can
      // hold it while the FIFO is empty.
      rd_data_d = head_word;
    end

    case ({wr_acc, rd_acc})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase

    // Flags are decoded from the next occupancy and registered, so they
    // change one cycle after the accepting edge and never glitch.
    full_d  = (fill_d == DEPTH_C);
    empty_d = (fill_d == '0);
    af_d    = (fill_d >= AF_C);
    ae_d    = (fill_d <= AE_C);

    // Sticky errors: a new set condition beats a simultaneous clear.
    ovf_d = ovf_q;
    if (clear_errors) begin
      ovf_d = 1'b0;
    end
    if (write_enable && full_q) begin
      ovf_d = 1'b1;
    end

    unf_d = unf_q;
    if (clear_errors) begin
      unf_d = 1'b0;
    end
    if (read_enable && empty_q) begin
      unf_d = 1'b1;
    end
  end

  // Control and status registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      af_q      <= 1'b0;
      ae_q      <= 1'b1;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      af_q      <= af_d;
      ae_q      <= ae_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Memory write port; a write coinciding with reset is discarded.
  always_ff @(posedge clock) begin
    if (reset_n && wr_acc) begin
      mem[wr_ptr_q] <= write_data;
    end
  end

  // Read data selection depends on the read mode.
  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is shown directly from the array while data is present;
      // the selector is a registered flag, so there is no input-to-output path.
      assign read_data = empty_q ? rd_data_q : head_word;
    end else begin : g_std
      assign read_data = rd_data_q;
    end
  endgenerate

  assign write_full   = full_q;
  assign read_empty   = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign fill_level   = fill_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Testbench for sync_fifo_flagged: table-driven vectors for the standard
// read mode, plus hand-written sequences for FWFT, wrap-around and reset.
module tb_sync_fifo_flagged;

  logic       clk;
  logic       rst_n;
  logic       we;
  logic [7:0] wd;
  logic       re;
  logic       clr;

  logic [7:0] rd0, rd1;
  logic       full0, full1, empty0, empty1, af0, af1, ae0, ae1;
  logic [3:0] fill0, fill1;
  logic       ov0, ov1, un0, un1;

  int checks   = 0;
  int failures = 0;

  sync_fifo_flagged #(.FWFT(0)) u_std (
    .clock(clk), .reset_n(rst_n), .write_enable(we), .write_data(wd),
    .read_enable(re), .read_data(rd0), .write_full(full0), .read_empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .fill_level(fill0),
    .overflow(ov0), .underflow(un0), .clear_errors(clr)
  );

  sync_fifo_flagged #(.FWFT(1)) u_fwft (
    .clock(clk), .reset_n(rst_n), .write_enable(we), .write_data(wd),
    .read_enable(re), .read_data(rd1), .write_full(full1), .read_empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .fill_level(fill1),
    .overflow(ov1), .underflow(un1), .clear_errors(clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n, we;
    logic [7:0] wd;
    logic       re, clr;
    logic [7:0] rd;
    logic [3:0] fill;
    logic       full, empty, af, ae, ov, un;
  } vec_t;

  function automatic vec_t mk(logic r, logic w, logic [7:0] d, logic rr, logic c,
                              logic [7:0] erd, logic [3:0] ef, logic efu, logic eem,
                              logic eaf, logic eae, logic eov, logic eun);
    vec_t v;
    v.rst_n = r; v.we = w; v.wd = d; v.re = rr; v.clr = c;
    v.rd = erd; v.fill = ef; v.full = efu; v.empty = eem;
    v.af = eaf; v.ae = eae; v.ov = eov; v.un = eun;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(logic r, logic w, logic [7:0] d, logic rr, logic c);
    rst_n = r; we = w; wd = d; re = rr; clr = c;
    @(posedge clk);
    #1;
  endtask

  localparam int NV = 34;
  vec_t tbl [NV];

  initial begin
    clk = 1'b0; rst_n = 1'b0; we = 1'b0; wd = '0; re = 1'b0; clr = 1'b0;

    //              rst we wd    re clr | rd    fill full emp af ae ov un
    tbl[0]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 1, 0, 0);
    tbl[1]  = mk(1, 1, 8'hA1, 0, 0, 8'h00, 1, 0, 0, 0, 1, 0, 0);
    tbl[2]  = mk(1, 1, 8'hB2, 0, 0, 8'h00, 2, 0, 0, 0, 1, 0, 0);
    tbl[3]  = mk(1, 1, 8'hC3, 0, 0, 8'h00, 3, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(1, 0, 8'h00, 1, 0, 8'hA1, 2, 0, 0, 0, 1, 0, 0);
    tbl[5]  = mk(1, 0, 8'h00, 1, 0, 8'hB2, 1, 0, 0, 0, 1, 0, 0);
    tbl[6]  = mk(1, 0, 8'h00, 1, 0, 8'hC3, 0, 0, 1, 0, 1, 0, 0);
    tbl[7]  = mk(1, 1, 8'h10, 0, 0, 8'hC3, 1, 0, 0, 0, 1, 0, 0);
    tbl[8]  = mk(1, 1, 8'h11, 0, 0, 8'hC3, 2, 0, 0, 0, 1, 0, 0);
    tbl[9]  = mk(1, 1, 8'h12, 0, 0, 8'hC3, 3, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk(1, 1, 8'h13, 0, 0, 8'hC3, 4, 0, 0, 0, 0, 0, 0);
    tbl[11] = mk(1, 1, 8'h14, 0, 0, 8'hC3, 5, 0, 0, 0, 0, 0, 0);
    tbl[12] = mk(1, 1, 8'h15, 0, 0, 8'hC3, 6, 0, 0, 1, 0, 0, 0);
    tbl[13] = mk(1, 1, 8'h16, 0, 0, 8'hC3, 7, 0, 0, 1, 0, 0, 0);
    tbl[14] = mk(1, 1, 8'h17, 0, 0, 8'hC3, 8, 1, 0, 1, 0, 0, 0);
    tbl[15] = mk(1, 1, 8'h18, 0, 0, 8'hC3, 8, 1, 0, 1, 0, 1, 0);
    tbl[16] = mk(1, 1, 8'h19, 0, 0, 8'hC3, 8, 1, 0, 1, 0, 1, 0);
    tbl[17] = mk(1, 1, 8'h1A, 0, 0, 8'hC3, 8, 1, 0, 1, 0, 1, 0);
    tbl[18] = mk(1, 0, 8'h00, 0, 1, 8'hC3, 8, 1, 0, 1, 0, 0, 0);
    tbl[19] = mk(1, 1, 8'h99, 1, 0, 8'h10, 7, 0, 0, 1, 0, 1, 0);
    tbl[20] = mk(1, 0, 8'h00, 1, 0, 8'h11, 6, 0, 0, 1, 0, 1, 0);
    tbl[21] = mk(1, 0, 8'h00, 1, 0, 8'h12, 5, 0, 0, 0, 0, 1, 0);
    tbl[22] = mk(1, 0, 8'h00, 1, 0, 8'h13, 4, 0, 0, 0, 0, 1, 0);
    tbl[23] = mk(1, 0, 8'h00, 1, 0, 8'h14, 3, 0, 0, 0, 0, 1, 0);
    tbl[24] = mk(1, 0, 8'h00, 1, 0, 8'h15, 2, 0, 0, 0, 1, 1, 0);
    tbl[25] = mk(1, 0, 8'h00, 1, 0, 8'h16, 1, 0, 0, 0, 1, 1, 0);
    tbl[26] = mk(1, 0, 8'h00, 1, 0, 8'h17, 0, 0, 1, 0, 1, 1, 0);
    tbl[27] = mk(1, 0, 8'h00, 1, 0, 8'h17, 0, 0, 1, 0, 1, 1, 1);
    tbl[28] = mk(1, 0, 8'h00, 0, 1, 8'h17, 0, 0, 1, 0, 1, 0, 0);
    tbl[29] = mk(1, 1, 8'h5A, 1, 0, 8'h17, 1, 0, 0, 0, 1, 0, 1);
    tbl[30] = mk(1, 0, 8'h00, 0, 1, 8'h17, 1, 0, 0, 0, 1, 0, 0);
    tbl[31] = mk(1, 0, 8'h00, 1, 0, 8'h5A, 0, 0, 1, 0, 1, 0, 0);
    tbl[32] = mk(1, 0, 8'h00, 1, 1, 8'h5A, 0, 0, 1, 0, 1, 0, 1);
    tbl[33] = mk(1, 0, 8'h00, 0, 1, 8'h5A, 0, 0, 1, 0, 1, 0, 0);

    // Standard-mode vectors, checked against the FWFT=0 instance.
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].rst_n, tbl[i].we, tbl[i].wd, tbl[i].re, tbl[i].clr);
      $display("vec %0d: rd=%02h fill=%0d full=%b empty=%b af=%b ae=%b ov=%b un=%b",
               i, rd0, fill0, full0, empty0, af0, ae0, ov0, un0);
      chk($sformatf("v%0d read_data", i),    32'(rd0),    32'(tbl[i].rd));
      chk($sformatf("v%0d fill_level", i),   32'(fill0),  32'(tbl[i].fill));
      chk($sformatf("v%0d write_full", i),   32'(full0),  32'(tbl[i].full));
      chk($sformatf("v%0d read_empty", i),   32'(empty0), 32'(tbl[i].empty));
      chk($sformatf("v%0d almost_full", i),  32'(af0),    32'(tbl[i].af));
      chk($sformatf("v%0d almost_empty", i), 32'(ae0),    32'(tbl[i].ae));
      chk($sformatf("v%0d overflow", i),     32'(ov0),    32'(tbl[i].ov));
      chk($sformatf("v%0d underflow", i),    32'(un0),    32'(tbl[i].un));
    end

    // FWFT: head word falls through without a read, pops advance it.
    drive(0, 0, 8'h00, 0, 0);
    chk("fwft reset read_data", 32'(rd1), 32'h00);
    chk("fwft reset empty", 32'(empty1), 32'd1);
    drive(1, 1, 8'h77, 0, 0);
    $display("fwft write 77: rd=%02h empty=%b", rd1, empty1);
    chk("fwft first word", 32'(rd1), 32'h77);
    chk("fwft empty after write", 32'(empty1), 32'd0);
    drive(1, 0, 8'h00, 1, 0);
    $display("fwft pop: rd=%02h empty=%b", rd1, empty1);
    chk("fwft empty after pop", 32'(empty1), 32'd1);
    chk("fwft hold when empty", 32'(rd1), 32'h77);
    drive(1, 1, 8'h88, 0, 0);
    drive(1, 1, 8'h99, 0, 0);
    chk("fwft head stays first", 32'(rd1), 32'h88);
    drive(1, 0, 8'h00, 1, 0);
    $display("fwft pop: rd=%02h fill=%0d", rd1, fill1);
    chk("fwft next head", 32'(rd1), 32'h99);
    chk("fwft fill", 32'(fill1), 32'd1);

    // Wrap-around: 20 write/read pairs carry both pointers around the array.
    drive(0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 20; i++) begin
      logic [7:0] d;
      d = 8'(8'h40 + i);
      drive(1, 1, d, 0, 0);
      chk($sformatf("wrap%0d fwft head", i), 32'(rd1), 32'(d));
      drive(1, 0, 8'h00, 1, 0);
      $display("wrap %0d: wrote %02h std=%02h fill=%0d", i, d, rd0, fill0);
      chk($sformatf("wrap%0d std data", i), 32'(rd0), 32'(d));
      chk($sformatf("wrap%0d fill", i), 32'(fill0), 32'd0);
    end

    // Reset mid-stream discards stored words, even with a write pending.
    drive(1, 1, 8'hD1, 0, 0);
    drive(1, 1, 8'hD2, 0, 0);
    drive(0, 1, 8'hD3, 0, 0);
    $display("mid reset: fill=%0d empty=%b rd=%02h", fill0, empty0, rd0);
    chk("midrst fill", 32'(fill0), 32'd0);
    chk("midrst empty", 32'(empty0), 32'd1);
    chk("midrst read_data", 32'(rd0), 32'h00);
    drive(1, 1, 8'hE1, 0, 0);
    drive(1, 0, 8'h00, 1, 0);
    chk("post reset data", 32'(rd0), 32'hE1);
    chk("post reset empty", 32'(empty0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
